// File: rtl/uart_frame_decoder.sv
// Frame decoder between uart_rx and per-channel consumers: collects a payload,
// optional XOR checksum and terminator, and commits the payload atomically.
module uart_frame_decoder #(
    parameter int          N_CH        = 3,
    parameter int          CH_BYTES    = 1,
    parameter logic [7:0]  TERM        = 8'h0A,
    parameter bit          USE_CSUM    = 1'b1,
    parameter int          TIMEOUT_CYC = 270000,
    // Value frame_count takes on reset.
    parameter logic [15:0] COUNT_RST   = 16'h0000
) (
    input  logic                       clk,
    input  logic                       reset_uart,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    output logic [8*N_CH*CH_BYTES-1:0] frame_data,
    output logic                       frame_valid,
    output logic                       frame_err,
    output logic [1:0]                 err_code,
    output logic [15:0]                frame_count,
    output logic                       busy
);

    localparam int P     = N_CH * CH_BYTES;
    localparam int IDX_W = (P > 1) ? $clog2(P) : 1;
    localparam int TMO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(P - 1);
    // The counter is compared one short of the limit so the error lands on
    // exactly the TIMEOUT_CYC-th idle edge after the last byte.
    localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? TMO_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        PAYLOAD,
        CSUM,
        TERMS,
        HUNT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] byte_idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W-1:0] wr_idx;
    logic [7:0]       xor_acc;
    logic [7:0]       xor_nxt;
    logic             csum_ok;
    logic             csum_ok_nxt;
    logic [TMO_W-1:0] idle_cnt;
    logic [8*P-1:0]   shadow;
    logic             shadow_wr;
    logic             commit;
    logic             err_fire;
    logic [1:0]       err_nxt;
    logic             tmo_hit;

    assign tmo_hit = (TIMEOUT_CYC > 0) && (state != IDLE) && !rx_valid && (idle_cnt == TMO_LAST);
    assign busy    = (state == PAYLOAD) || (state == CSUM) || (state == TERMS);

    always_comb begin
        state_nxt   = state;
        idx_nxt     = byte_idx;
        xor_nxt     = xor_acc;
        csum_ok_nxt = csum_ok;
        wr_idx      = byte_idx;
        shadow_wr   = 1'b0;
        commit      = 1'b0;
        err_fire    = 1'b0;
        err_nxt     = err_code;
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    shadow_wr = 1'b1;
                    wr_idx    = '0;
                    xor_nxt   = rx_data;
                    idx_nxt   = IDX_W'(1);
                    if (P > 1)
                        state_nxt = PAYLOAD;
                    else
                        state_nxt = USE_CSUM ? CSUM : TERMS;
                end
                PAYLOAD: begin
                    shadow_wr = 1'b1;
                    xor_nxt   = xor_acc ^ rx_data;
                    idx_nxt   = byte_idx + 1'b1;
                    if (byte_idx == IDX_LAST)
                        state_nxt = USE_CSUM ? CSUM : TERMS;
                end
                CSUM: begin
                    csum_ok_nxt = (rx_data == xor_acc);
                    state_nxt   = TERMS;
                end
                TERMS: begin
                    // A wrong terminator takes priority: the stream is out of
                    // step, so hunt for the next terminator before restarting.
                    if (rx_data != TERM) begin
                        err_fire  = 1'b1;
                        err_nxt   = 2'd1;
                        state_nxt = HUNT;
                    end else if (!csum_ok) begin
                        err_fire  = 1'b1;
                        err_nxt   = 2'd2;
                        state_nxt = IDLE;
                    end else begin
                        commit    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                HUNT: begin
                    if (rx_data == TERM)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (tmo_hit) begin
            state_nxt = IDLE;
            if (state != HUNT) begin
                err_fire = 1'b1;
                err_nxt  = 2'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_uart) begin
        if (reset_uart) begin
            state       <= IDLE;
            byte_idx    <= '0;
            csum_ok     <= !USE_CSUM;
            idle_cnt    <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'd0;
            frame_count <= COUNT_RST;
        end else begin
            state       <= state_nxt;
            byte_idx    <= idx_nxt;
            csum_ok     <= USE_CSUM ? csum_ok_nxt : 1'b1;
            frame_valid <= commit;
            frame_err   <= err_fire;
            err_code    <= err_nxt;
            if (commit) begin
                frame_data  <= shadow;
                frame_count <= frame_count + 16'd1;
            end
            if (rx_valid || (state == IDLE) || tmo_hit)
                idle_cnt <= '0;
            else if (TIMEOUT_CYC > 0)
                idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Shadow payload and running XOR are pure datapath and need no reset.
    always_ff @(posedge clk) begin
        xor_acc <= xor_nxt;
        if (shadow_wr) begin
            for (int k = 0; k < P; k++) begin
                if (wr_idx == IDX_W'(k))
                    shadow[8*(P-k)-1 -: 8] <= rx_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Bench for uart_frame_decoder: frame-level reference model compared every
// cycle, directed frames with literal expectations, randomized traffic.
module tb_uart_frame_decoder;

    localparam logic [7:0] TERM = 8'h0A;
    localparam int         TMO  = 100;
    localparam int         P    = 3;

    logic        clk = 1'b0;
    logic        reset_uart = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [23:0] frame_data;
    logic        frame_valid;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [15:0] frame_count;
    logic        busy;

    logic        v_valid = 1'b0;
    logic [7:0]  v_data = 8'h00;
    logic [31:0] v_frame_data;
    logic        v_frame_valid;
    logic        v_frame_err;
    logic [1:0]  v_err_code;
    logic [15:0] v_frame_count;
    logic        v_busy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    uart_frame_decoder #(
        .N_CH(3), .CH_BYTES(1), .TERM(8'h0A), .USE_CSUM(1'b1), .TIMEOUT_CYC(TMO)
    ) u_dut (
        .clk(clk), .reset_uart(reset_uart), .rx_valid(rx_valid), .rx_data(rx_data),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_err(frame_err),
        .err_code(err_code), .frame_count(frame_count), .busy(busy)
    );

    uart_frame_decoder #(
        .N_CH(2), .CH_BYTES(2), .TERM(8'h0A), .USE_CSUM(1'b0), .TIMEOUT_CYC(TMO),
        .COUNT_RST(16'hFFFF)
    ) u_var (
        .clk(clk), .reset_uart(reset_uart), .rx_valid(v_valid), .rx_data(v_data),
        .frame_data(v_frame_data), .frame_valid(v_frame_valid), .frame_err(v_frame_err),
        .err_code(v_err_code), .frame_count(v_frame_count), .busy(v_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collects whole frames as byte lists and judges them.
    logic [7:0]  q[$];
    bit          hunting;
    int          idle;
    logic [7:0]  m_x;
    logic [23:0] m_data;
    logic        m_valid;
    logic        m_err;
    logic [1:0]  m_code;
    logic [15:0] m_count;

    initial forever begin
        @(posedge clk or posedge reset_uart);
        if (reset_uart) begin
            q.delete();
            hunting = 1'b0;
            idle    = 0;
            m_data  = '0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_code  = 2'd0;
            m_count = 16'd0;
        end else begin
            m_valid = 1'b0;
            m_err   = 1'b0;
            if (rx_valid) begin
                idle = 0;
                if (hunting) begin
                    hunting = (rx_data != TERM);
                end else begin
                    q.push_back(rx_data);
                    if (q.size() == P + 2) begin
                        m_x = 8'h00;
                        for (int i = 0; i < P; i++) m_x ^= q[i];
                        if (q[P+1] != TERM) begin
                            m_err = 1'b1; m_code = 2'd1; hunting = 1'b1;
                        end else if (m_x != q[P]) begin
                            m_err = 1'b1; m_code = 2'd2;
                        end else begin
                            m_data  = {q[0], q[1], q[2]};
                            m_valid = 1'b1;
                            m_count = m_count + 16'd1;
                        end
                        q.delete();
                    end
                end
            end else if (q.size() != 0 || hunting) begin
                idle++;
                if (idle == TMO) begin
                    if (!hunting) begin
                        m_err = 1'b1; m_code = 2'd3;
                    end
                    q.delete();
                    hunting = 1'b0;
                    idle    = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en && !reset_uart) begin
            check("cmp_frame_data",  32'(frame_data),  32'(m_data));
            check("cmp_frame_valid", 32'(frame_valid), 32'(m_valid));
            check("cmp_frame_err",   32'(frame_err),   32'(m_err));
            check("cmp_err_code",    32'(err_code),    32'(m_code));
            check("cmp_frame_count", 32'(frame_count), 32'(m_count));
            check("cmp_busy",        32'(busy),        32'(q.size() != 0));
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic vsend(input logic [7:0] b);
        @(posedge clk);
        #1;
        v_valid = 1'b1;
        v_data  = b;
    endtask

    task automatic vgap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            v_valid = 1'b0;
        end
    endtask

    task automatic send5(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input logic [7:0] e);
        send(a); send(b); send(c); send(d); send(e);
    endtask

    function automatic int rand_gap();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 70) return 0;
        if (r < 97) return int'($urandom_range(1, 4));
        return int'($urandom_range(90, 110));
    endfunction

    initial begin
        logic [7:0] bq[$];
        logic [7:0] b;
        logic [7:0] cs;
        int         kind;
        int         n;

        repeat (3) @(posedge clk);
        #1;
        check("rst_frame_data",  32'(frame_data),  32'h0);
        check("rst_frame_valid", 32'(frame_valid), 32'h0);
        check("rst_frame_err",   32'(frame_err),   32'h0);
        check("rst_err_code",    32'(err_code),    32'h0);
        check("rst_frame_count", 32'(frame_count), 32'h0);
        check("rst_busy",        32'(busy),        32'h0);
        reset_uart = 1'b0;
        cmp_en     = 1'b1;
        gap(2);

        send5(8'h14, 8'h00, 8'h01, 8'h15, 8'h0A);
        gap(1);
        check("good_valid", 32'(frame_valid), 32'h1);
        check("good_data",  32'(frame_data),  32'h140001);
        check("good_count", 32'(frame_count), 32'h1);
        check("good_busy",  32'(busy),        32'h0);
        gap(1);
        check("good_valid_pulse", 32'(frame_valid), 32'h0);

        send5(8'h14, 8'h00, 8'h01, 8'h16, 8'h0A);
        gap(1);
        check("csum_err",   32'(frame_err),   32'h1);
        check("csum_code",  32'(err_code),    32'h2);
        check("csum_data",  32'(frame_data),  32'h140001);
        check("csum_count", 32'(frame_count), 32'h1);
        send5(8'h01, 8'h02, 8'h03, 8'h00, 8'h0A);
        gap(1);
        check("after_csum_data", 32'(frame_data), 32'h010203);
        check("code_holds",      32'(err_code),   32'h2);

        send5(8'h14, 8'h00, 8'h01, 8'h15, 8'h0B);
        send(8'h55);
        check("term_err",  32'(frame_err), 32'h1);
        check("term_code", 32'(err_code),  32'h1);
        send(8'h0A);
        send5(8'h22, 8'h33, 8'h44, 8'h55, 8'h0A);
        gap(1);
        check("resync_data",  32'(frame_data),  32'h223344);
        check("resync_count", 32'(frame_count), 32'h3);

        send(8'h14); send(8'h00);
        gap(TMO);
        check("tmo_not_yet", 32'(frame_err), 32'h0);
        gap(1);
        check("tmo_err",   32'(frame_err),   32'h1);
        check("tmo_code",  32'(err_code),    32'h3);
        check("tmo_busy",  32'(busy),        32'h0);
        check("tmo_count", 32'(frame_count), 32'h3);
        gap(3);

        send(8'h14); send(8'h00);
        gap(TMO - 1);
        send(8'h01);
        gap(1);
        check("edge_byte_no_err", 32'(frame_err), 32'h0);
        check("edge_byte_busy",   32'(busy),      32'h1);
        send(8'h15); send(8'h0A);
        gap(1);
        check("edge_frame_data", 32'(frame_data), 32'h140001);

        send5(8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h0A);
        send(8'h01);
        check("b2b_valid", 32'(frame_valid), 32'h1);
        check("b2b_data",  32'(frame_data),  32'hA55A00);
        send(8'h02); send(8'h03); send(8'h00); send(8'h0A);
        gap(1);
        check("b2b_next_data",  32'(frame_data),  32'h010203);
        check("b2b_next_count", 32'(frame_count), 32'h6);

        send(8'h14); send(8'h00);
        gap(1);
        #2;
        reset_uart = 1'b1;
        #1;
        check("arst_data",  32'(frame_data),  32'h0);
        check("arst_count", 32'(frame_count), 32'h0);
        check("arst_err",   32'(frame_err),   32'h0);
        check("arst_code",  32'(err_code),    32'h0);
        check("arst_busy",  32'(busy),        32'h0);
        @(posedge clk);
        #1;
        reset_uart = 1'b0;
        send5(8'h01, 8'h02, 8'h03, 8'h00, 8'h0A);
        gap(1);
        check("arst_frame_data",  32'(frame_data),  32'h010203);
        check("arst_frame_count", 32'(frame_count), 32'h1);

        for (int f = 0; f < 250; f++) begin
            kind = int'($urandom_range(0, 9));
            bq.delete();
            cs = 8'h00;
            for (int i = 0; i < P; i++) begin
                b = 8'($urandom);
                bq.push_back(b);
                cs ^= b;
            end
            if (kind == 0) cs ^= 8'($urandom_range(1, 255));
            bq.push_back(cs);
            if (kind == 1) begin
                b = 8'($urandom);
                if (b == TERM) b = 8'h0B;
                bq.push_back(b);
                n = int'($urandom_range(0, 3));
                repeat (n) bq.push_back(8'($urandom));
            end
            bq.push_back(TERM);
            if (kind == 2) begin
                n = int'($urandom_range(1, P + 1));
                while (bq.size() > n) void'(bq.pop_back());
            end
            foreach (bq[i]) begin
                send(bq[i]);
                gap(rand_gap());
            end
            if (kind == 2) gap(TMO + 2);
        end
        gap(2);

        check("var_rst_count", 32'(v_frame_count), 32'hFFFF);
        vsend(8'h12); vsend(8'h34); vsend(8'h56); vsend(8'h78); vsend(8'h0A);
        vgap(1);
        check("var_valid", 32'(v_frame_valid), 32'h1);
        check("var_data",  v_frame_data,       32'h12345678);
        check("var_wrap",  32'(v_frame_count), 32'h0);
        check("var_busy",  32'(v_busy),        32'h0);
        vsend(8'hAB); vsend(8'hCD); vsend(8'hEF); vsend(8'h01); vsend(8'h0A);
        vgap(1);
        check("var_data2",  v_frame_data,       32'hABCDEF01);
        check("var_count2", 32'(v_frame_count), 32'h1);
        vsend(8'h11); vsend(8'h22); vsend(8'h33); vsend(8'h44); vsend(8'h55);
        vgap(1);
        check("var_term_err",  32'(v_frame_err), 32'h1);
        check("var_term_code", 32'(v_err_code),  32'h1);
        check("var_term_data", v_frame_data,     32'hABCDEF01);
        vgap(2);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_decoder.md
# uart_frame_decoder

Parametrised frame decoder that sits between the `uart_rx` byte receiver and the per-channel consumers, typically `PWM_control` instances.
- Frame format: `N_CH*CH_BYTES` payload bytes, an optional XOR checksum byte, then a terminator byte.
- Payload is held in a shadow register and committed atomically only when the whole frame is good, so consumers never see a partially updated frame.
- Adds capabilities over the fixed 3-byte parser: checksum checking, an inter-byte timeout, terminator resynchronisation, error reporting and a frame counter.

## Interface
Parameters:
- `N_CH`, 3: number of channels.
- `CH_BYTES`, 1: bytes per channel, big-endian. `P = N_CH*CH_BYTES`, range 1..16.
- `TERM`, 8'h0A: terminator byte.
- `USE_CSUM`, 1: 1 = a checksum byte follows the payload; 0 = no checksum byte.
- `TIMEOUT_CYC`, 270000: maximum idle clock cycles between bytes inside a frame. 0 disables the timeout.

Ports:
- `clk`, in, 1: the single clock; all logic on the rising edge.
- `reset_uart`, in, 1: asynchronous, active-high reset.
- `rx_valid`, in, 1: one-cycle byte strobe from `uart_rx`.
- `rx_data`, in, 8: received byte, qualified by `rx_valid`.
- `frame_data`, out, `8*P`: last committed payload. The first received byte occupies the MSBs.
- `frame_valid`, out, 1: one-cycle pulse on each commit.
- `frame_err`, out, 1: one-cycle pulse on each error.
- `err_code`, out, 2: 1 = bad terminator, 2 = bad checksum, 3 = timeout. Holds its value until the next error.
- `frame_count`, out, 16: number of committed frames; wraps modulo 2^16.
- `busy`, out, 1: high while in `PAYLOAD`, `CSUM` or `TERMS`.

## Operation
States: `IDLE`, `PAYLOAD`, `CSUM`, `TERMS`, `HUNT`.

- **IDLE**
  - An `rx_valid` byte is written to shadow byte 0 and the running XOR is set to that byte.
  - Next state is `PAYLOAD` if `P>1`, otherwise `CSUM` (or `TERMS` when `USE_CSUM=0`).
- **PAYLOAD**
  - Byte k (0-based) is written to shadow bits `[8*(P-k)-1 -: 8]` and XORed into the running XOR.
  - After byte `P-1`, next state is `CSUM` (or `TERMS` when `USE_CSUM=0`).
- **CSUM**
  - The received byte is compared with the running XOR.
  - The result is latched in `csum_ok`; next state is `TERMS`.
  - When `USE_CSUM=0`, `csum_ok` is forced to 1.
- **TERMS** (evaluated in this order):
  - If `rx_data!=TERM`: error code 1, next state `HUNT`.
  - Else if `!csum_ok`: error code 2, next state `IDLE`.
  - Otherwise: copy shadow to `frame_data`, pulse `frame_valid`, increment `frame_count`, next state `IDLE`.
- **HUNT**
  - Bytes are discarded until a byte equal to `TERM` arrives; next state is then `IDLE`.
  - A timeout in `HUNT` returns to `IDLE` silently, with no error pulse.
- **Timeout**
  - The idle counter clears on every accepted byte and in `IDLE`.
  - It counts clock cycles with `rx_valid` low while `busy` or in `HUNT`.
  - On reaching `TIMEOUT_CYC`: error code 3 (suppressed in `HUNT`), next state `IDLE`, shadow contents discarded.
- **Error handling**
  - `frame_data` and `frame_count` never change on any error.
  - The shadow register is not cleared; it is overwritten by the next frame.
- **Width rules**
  - The counter width is `$clog2(TIMEOUT_CYC+1)`.
  - The byte index width is `$clog2(P)`, minimum 1.
  - `frame_count` is unsigned and wraps from 16'hFFFF to 0 with no flag.

## Timing
- **Reset values:**
  - Outputs: `frame_data`=0, `frame_valid`=0, `frame_err`=0, `err_code`=0, `frame_count`=0, `busy`=0.
  - Internal: state `IDLE`, counters 0.
  - Reset asserted mid-frame aborts the frame, with no error pulse.
- **Byte rate:** back-to-back `rx_valid` on consecutive cycles must be accepted with no byte lost.
- **Latency:**
  - The terminator sampled at edge E updates `frame_data`, `frame_valid`, `frame_count` and `busy` together at edge E.
  - They are visible in the cycle after E.
  - `frame_valid` is high for exactly that one cycle.
- **Error pulse:** `frame_err` and `err_code` are registered on the same edge that decides the error.
- **Timeout exactness:** with the last byte at edge E0 and no `rx_valid` on edges E0+1..E0+`TIMEOUT_CYC`, the error registers at edge E0+`TIMEOUT_CYC`.
- **Simultaneous events:** `rx_valid` on the expiry edge wins: the byte is processed and no timeout is declared.
- **Next-frame start:** a byte arriving in the cycle that `frame_valid` is high is the first byte of the next frame and is accepted.

## Test plan
- **Good frame** (N_CH=3, CH_BYTES=1, USE_CSUM=1): bytes 14,00,01, csum 15, 0A -> `frame_data`=24'h140001; one `frame_valid` pulse one cycle after 0A; `frame_count`=1.
- **Bad checksum:** same frame with csum 16 -> `frame_err` pulse, `err_code`=2; `frame_data` and `frame_count` unchanged. A following good frame 01,02,03,00,0A -> `frame_data`=24'h010203.
- **Bad terminator and resync:** 14,00,01,15,0B,55,0A, then a good frame 22,33,44,55,0A.
  - `err_code`=1 at byte 0B; 55 and the first 0A are discarded.
  - Then `frame_data`=24'h223344.
- **Timeout** (TIMEOUT_CYC=100): bytes 14,00, then idle.
  - `frame_err` registered exactly 100 edges after the 00 byte, `err_code`=3.
  - Repeat with a byte on edge 100 -> no error.
- **Async reset mid-frame:** assert `reset_uart` between two payload bytes -> all outputs at reset values immediately, with no error pulse. A full frame after release decodes correctly.
- **Parameter variant:** N_CH=2, CH_BYTES=2, USE_CSUM=0, bytes back-to-back 12,34,56,78,0A -> `frame_data`=32'h12345678. Preload `frame_count`=16'hFFFF -> wraps to 0.
